// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the PS/2 keyboard front end and the player controller.
//   * KEY_* : bit positions inside the held-key vector (keydown[4:0])
//   * SC_*  : scan-code set 2 constants (prefixes, mapped keys, Enter)
//   * FLAG_*/key_map(): the physical-key flag table used by the decoder
//   * rx_state_t / dec_state_t : receiver and decoder state encodings
// ---------------------------------------------------------------------------
package game_pkg;

    // Held-key vector bit indices (consumed by the player controller)
    localparam int KEY_UP    = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_JUMP  = 4;

    // Scan-code set 2 constants
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    // One held flag per physical key
    localparam int FLAG_W     = 0;
    localparam int FLAG_A     = 1;
    localparam int FLAG_D     = 2;
    localparam int FLAG_S     = 3;
    localparam int FLAG_SPACE = 4;
    localparam int FLAG_UP    = 5;
    localparam int FLAG_LEFT  = 6;
    localparam int FLAG_RIGHT = 7;
    localparam int FLAG_DOWN  = 8;
    localparam int NUM_KEYS   = 9;

    typedef struct packed {
        logic       ext;    // 1: code only valid after an E0 prefix
        logic [7:0] code;
    } key_map_t;

    // Flag index -> (extended?, scan code)
    function automatic key_map_t key_map(input int idx);
        key_map_t m;
        m = '{ext: 1'b0, code: 8'h00};
        case (idx)
            FLAG_W:     m = '{ext: 1'b0, code: SC_W};
            FLAG_A:     m = '{ext: 1'b0, code: SC_A};
            FLAG_D:     m = '{ext: 1'b0, code: SC_D};
            FLAG_S:     m = '{ext: 1'b0, code: SC_S};
            FLAG_SPACE: m = '{ext: 1'b0, code: SC_SPACE};
            FLAG_UP:    m = '{ext: 1'b1, code: SC_UP};
            FLAG_LEFT:  m = '{ext: 1'b1, code: SC_LEFT};
            FLAG_RIGHT: m = '{ext: 1'b1, code: SC_RIGHT};
            FLAG_DOWN:  m = '{ext: 1'b1, code: SC_DOWN};
            default:    m = '{ext: 1'b0, code: 8'h00};
        endcase
        return m;
    endfunction

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_BRK,
        DEC_EXT,
        DEC_EXT_BRK
    } dec_state_t;

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver: 2-FF synchronizers, ps2_clk glitch
// filter, 11-bit frame FSM (start, 8 data LSB first, odd parity, stop) and
// a mid-frame timeout.
// Ports:
//   clk, rst        system clock, synchronous active-low reset
//   ps2_clk         raw PS/2 clock pin (asynchronous)
//   ps2_data        raw PS/2 data pin (asynchronous)
//   rx_byte         received byte, valid while byte_valid is high
//   byte_valid      one-cycle pulse, good frame received
//   frame_err       one-cycle pulse, parity/stop/timeout failure
// ---------------------------------------------------------------------------
module ps2_rx
    import game_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          r_filt;
    logic [FW-1:0] r_filt_cnt;

    logic          w_clk_s;
    logic          w_data;
    logic          w_flip;
    logic          w_fall;

    assign w_clk_s = r_clk_sync[1];
    assign w_data  = r_data_sync[1];

    // The filtered level flips on the FILTER_LEN-th consecutive sample that
    // disagrees with it; a flip from 1 to 0 is the sample edge.
    assign w_flip = (w_clk_s != r_filt) && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_fall = w_flip && r_filt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_filt      <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
            if (w_clk_s == r_filt) begin
                r_filt_cnt <= '0;
            end else if (w_flip) begin
                r_filt     <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    // Frame FSM
    rx_state_t     r_state, w_state_next;
    logic [7:0]    r_shift, w_shift_next;
    logic [2:0]    r_bit_cnt, w_bit_cnt_next;
    logic          r_par, w_par_next;      // running XOR, 1 means odd parity so far
    logic [TW-1:0] r_tmo, w_tmo_next;
    logic          r_valid, w_valid_next;
    logic          r_err, w_err_next;

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_par_next     = r_par;
        w_valid_next   = 1'b0;
        w_err_next     = 1'b0;
        w_tmo_next     = (r_state == RX_IDLE || w_fall) ? '0 : r_tmo + TW'(1);

        if (r_state != RX_IDLE && !w_fall && r_tmo == TW'(TIMEOUT - 1)) begin
            w_state_next = RX_IDLE;
            w_err_next   = 1'b1;
            w_tmo_next   = '0;
        end else if (w_fall) begin
            case (r_state)
                RX_IDLE: begin
                    // A high data line on an idle edge is ignored silently
                    if (!w_data) begin
                        w_state_next   = RX_DATA;
                        w_bit_cnt_next = 3'd0;
                        w_par_next     = 1'b0;
                    end
                end
                RX_DATA: begin
                    w_shift_next   = {w_data, r_shift[7:1]};
                    w_par_next     = r_par ^ w_data;
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    w_par_next   = r_par ^ w_data;
                    w_state_next = RX_STOP;
                end
                RX_STOP: begin
                    w_state_next = RX_IDLE;
                    if (w_data && r_par) begin
                        w_valid_next = 1'b1;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                default: w_state_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= RX_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
            r_tmo     <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_par     <= w_par_next;
            r_tmo     <= w_tmo_next;
            r_valid   <= w_valid_next;
            r_err     <= w_err_next;
        end
    end

    // The shift register is untouched in the cycle after the stop edge
    assign rx_byte    = r_shift;
    assign byte_valid = r_valid;
    assign frame_err  = r_err;

endmodule

// File: rtl/ps2_keys.sv
// ---------------------------------------------------------------------------
// ps2_keys
// PS/2 keyboard front end: receives scan-code set 2 bytes, tracks make/break
// and E0-extended sequences, keeps one held flag per mapped key and drives
// the held-key vector for the player controller.
// Ports:
//   clk, rst        system clock, synchronous active-low reset
//   ps2_clk         raw PS/2 clock pin
//   ps2_data        raw PS/2 data pin
//   keydown[4:0]    held keys: up, left, right, down, jump
//   start           one-cycle pulse on an Enter make
//   frame_err       one-cycle pulse on a receive failure
// ---------------------------------------------------------------------------
module ps2_keys
    import game_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] keydown,
    output logic       start,
    output logic       frame_err
);

    logic [7:0] w_rx_byte;
    logic       w_valid;
    logic       w_err;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (w_rx_byte),
        .byte_valid (w_valid),
        .frame_err  (w_err)
    );

    // Decoder FSM
    dec_state_t r_dec, w_dec_next;
    logic       w_apply;        // a non-prefix byte completes a sequence
    logic       w_make;         // 1: make, 0: break
    logic       w_ext;          // sequence carried an E0 prefix
    logic       w_start_next;
    logic       r_start;

    always_comb begin
        w_dec_next   = r_dec;
        w_apply      = 1'b0;
        w_make       = 1'b0;
        w_ext        = 1'b0;
        w_start_next = 1'b0;

        if (w_err) begin
            // A lost byte may have been part of a sequence: drop any prefix
            w_dec_next = DEC_BASE;
        end else if (w_valid) begin
            case (r_dec)
                DEC_BASE: begin
                    if (w_rx_byte == SC_E0) begin
                        w_dec_next = DEC_EXT;
                    end else if (w_rx_byte == SC_F0) begin
                        w_dec_next = DEC_BRK;
                    end else begin
                        w_apply      = 1'b1;
                        w_make       = 1'b1;
                        w_start_next = (w_rx_byte == SC_ENTER);
                        w_dec_next   = DEC_BASE;
                    end
                end
                DEC_EXT: begin
                    if (w_rx_byte == SC_F0) begin
                        w_dec_next = DEC_EXT_BRK;
                    end else if (w_rx_byte == SC_E0) begin
                        w_dec_next = DEC_EXT;
                    end else begin
                        w_apply    = 1'b1;
                        w_make     = 1'b1;
                        w_ext      = 1'b1;
                        w_dec_next = DEC_BASE;
                    end
                end
                DEC_BRK: begin
                    if (w_rx_byte == SC_E0) begin
                        w_dec_next = DEC_EXT_BRK;
                    end else begin
                        w_apply    = 1'b1;
                        w_dec_next = DEC_BASE;
                    end
                end
                DEC_EXT_BRK: begin
                    w_apply    = 1'b1;
                    w_ext      = 1'b1;
                    w_dec_next = DEC_BASE;
                end
                default: w_dec_next = DEC_BASE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dec   <= DEC_BASE;
            r_start <= 1'b0;
        end else begin
            r_dec   <= w_dec_next;
            r_start <= w_start_next;
        end
    end

    // Held flags: a flag only reacts to its own code with a matching prefix,
    // so unmapped codes fall through untouched.
    logic [NUM_KEYS-1:0] w_held;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        localparam key_map_t KM = key_map(gi);
        logic r_flag;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_flag <= 1'b0;
            end else if (w_apply && (w_ext == KM.ext) && (w_rx_byte == KM.code)) begin
                r_flag <= w_make;
            end
        end

        assign w_held[gi] = r_flag;
    end

    // Plain and extended keys with the same meaning share one output bit
    assign keydown[KEY_UP]    = w_held[FLAG_W] | w_held[FLAG_UP];
    assign keydown[KEY_LEFT]  = w_held[FLAG_A] | w_held[FLAG_LEFT];
    assign keydown[KEY_RIGHT] = w_held[FLAG_D] | w_held[FLAG_RIGHT];
    assign keydown[KEY_DOWN]  = w_held[FLAG_S] | w_held[FLAG_DOWN];
    assign keydown[KEY_JUMP]  = w_held[FLAG_SPACE];

    assign start     = r_start;
    assign frame_err = w_err;

endmodule

// File: tb/tb_ps2_keys.sv
// ---------------------------------------------------------------------------
// tb_ps2_keys
// Self-checking bench for ps2_keys: directed scenarios followed by random
// scan-code traffic, compared against a prefix/held-set reference model.
// ---------------------------------------------------------------------------
module tb_ps2_keys;

    localparam int HALF = 20;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [4:0] keydown;
    logic       start;
    logic       frame_err;

    int total     = 0;
    int bad       = 0;
    int start_cnt = 0;
    int err_cnt   = 0;

    // Reference model: which (prefix, code) keys are held, plus pending prefixes
    bit held_plain [256];
    bit held_ext   [256];
    bit m_ext;
    bit m_brk;

    always #5 clk = ~clk;

    ps2_keys #(
        .FILTER_LEN (2),
        .TIMEOUT    (200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keydown   (keydown),
        .start     (start),
        .frame_err (frame_err)
    );

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (start)     start_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        tick(HALF);
        ps2_data = 1'b1;
    endtask

    function automatic logic [4:0] model_keys();
        logic [4:0] k;
        k[0] = held_plain[8'h1D] | held_ext[8'h75];
        k[1] = held_plain[8'h1C] | held_ext[8'h6B];
        k[2] = held_plain[8'h23] | held_ext[8'h74];
        k[3] = held_plain[8'h1B] | held_ext[8'h72];
        k[4] = held_plain[8'h29];
        return k;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            held_plain[i] = 1'b0;
            held_ext[i]   = 1'b0;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    // Returns the number of start pulses the byte should produce
    task automatic model_byte(input logic [7:0] b, output int starts);
        starts = 0;
        if (b == 8'hE0 && !(m_ext && m_brk)) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0 && !m_brk) begin
            m_brk = 1'b1;
        end else begin
            if (m_ext) held_ext[b]   = !m_brk;
            else       held_plain[b] = !m_brk;
            if (!m_ext && !m_brk && b == 8'h5A) starts = 1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int s0, e0, exp_start, exp_err;
        s0 = start_cnt;
        e0 = err_cnt;
        send_bits(frame_bits(b, bad_par, bad_stop), 11);
        if (bad_par || bad_stop) begin
            m_ext     = 1'b0;
            m_brk     = 1'b0;
            exp_start = 0;
            exp_err   = 1;
        end else begin
            model_byte(b, exp_start);
            exp_err = 0;
        end
        $display("frame %s byte=%02h badpar=%0d badstop=%0d keydown=%05b starts=%0d errs=%0d",
                 tag, b, bad_par, bad_stop, keydown, start_cnt - s0, err_cnt - e0);
        check({tag, ".keydown"}, 32'(keydown), 32'(model_keys()));
        check({tag, ".start"}, 32'(start_cnt - s0), 32'(exp_start));
        check({tag, ".err"}, 32'(err_cnt - e0), 32'(exp_err));
    endtask

    initial begin
        logic [7:0] pool [14];
        logic [7:0] b;
        int         e0;
        int         s0;
        bit         bp, bs;

        model_clear();

        // Reset state
        rst = 1'b0;
        tick(5);
        $display("reset keydown=%05b start=%0b frame_err=%0b", keydown, start, frame_err);
        check("reset.keydown", 32'(keydown), 32'h0);
        check("reset.start", 32'(start), 32'h0);
        check("reset.err", 32'(frame_err), 32'h0);
        rst = 1'b1;
        tick(5);

        // Plain make/break
        send_byte("w_make", 8'h1D, 0, 0);
        send_byte("w_brk_f0", 8'hF0, 0, 0);
        send_byte("w_brk", 8'h1D, 0, 0);

        // Extended keys overlapping plain keys
        send_byte("left_e0", 8'hE0, 0, 0);
        send_byte("left_make", 8'h6B, 0, 0);
        send_byte("a_make", 8'h1C, 0, 0);
        send_byte("left_brk_e0", 8'hE0, 0, 0);
        send_byte("left_brk_f0", 8'hF0, 0, 0);
        send_byte("left_brk", 8'h6B, 0, 0);
        send_byte("a_brk_f0", 8'hF0, 0, 0);
        send_byte("a_brk", 8'h1C, 0, 0);

        // Jump and Enter
        send_byte("space_make", 8'h29, 0, 0);
        send_byte("enter_make", 8'h5A, 0, 0);
        send_byte("enter_f0", 8'hF0, 0, 0);
        send_byte("enter_brk", 8'h5A, 0, 0);
        send_byte("enter_rep1", 8'h5A, 0, 0);
        send_byte("enter_rep2", 8'h5A, 0, 0);
        send_byte("space_f0", 8'hF0, 0, 0);
        send_byte("space_brk", 8'h29, 0, 0);

        // Parity error and prefix drop
        send_byte("d_badpar", 8'h23, 1, 0);
        send_byte("pfx_e0", 8'hE0, 0, 0);
        send_byte("pfx_badstop", 8'h00, 0, 1);
        send_byte("pfx_75", 8'h75, 0, 0);

        // Timeout mid-frame
        e0 = err_cnt;
        send_bits(frame_bits(8'h1B, 0, 0), 6);
        tick(250 - HALF);
        m_ext = 1'b0;
        m_brk = 1'b0;
        $display("timeout keydown=%05b errs=%0d", keydown, err_cnt - e0);
        check("timeout.err", 32'(err_cnt - e0), 32'd1);
        check("timeout.keydown", 32'(keydown), 32'(model_keys()));
        send_byte("s_make", 8'h1B, 0, 0);
        check("s_make.value", 32'(keydown), 32'b01000);

        // Reset mid-frame with everything held
        send_byte("all_w", 8'h1D, 0, 0);
        send_byte("all_a", 8'h1C, 0, 0);
        send_byte("all_d", 8'h23, 0, 0);
        send_byte("all_space", 8'h29, 0, 0);
        check("all.value", 32'(keydown), 32'b11111);
        s0 = start_cnt;
        send_bits(frame_bits(8'h72, 0, 0), 4);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        model_clear();
        $display("midreset keydown=%05b start=%0b frame_err=%0b", keydown, start, frame_err);
        check("midreset.keydown", 32'(keydown), 32'h0);
        check("midreset.start", 32'(start), 32'h0);
        check("midreset.err", 32'(frame_err), 32'h0);
        tick(HALF);
        send_byte("post_rst_w", 8'h1D, 0, 0);
        check("post_rst.value", 32'(keydown), 32'b00001);
        check("post_rst.nostart", 32'(start_cnt - s0), 32'd0);

        // Random traffic
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h23, 8'h1B, 8'h29,
                 8'h75, 8'h6B, 8'h74, 8'h72, 8'h5A, 8'hE1, 8'hF0};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
            else                           b = pool[$urandom_range(0, 13)];
            bp = ($urandom_range(0, 11) == 0);
            bs = !bp && ($urandom_range(0, 15) == 0);
            send_byte($sformatf("rnd%0d", n), b, bp, bs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
